// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: the fetch FSM encoding,
// the instruction field positions and the default reset PC.
package mips_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Instruction field positions
  localparam int OP_MSB     = 31;
  localparam int OP_LSB     = 26;
  localparam int JIDX_MSB   = 25;
  localparam int IMM_MSB    = 15;
  localparam int INSTR_W    = 32;

  // Sign-extended 16-bit immediate, scaled to a byte offset
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_next.sv
// Next-PC select: jump target, taken-branch target or the sequential PC.
// Only the low 26 instruction bits matter here, so only those are passed in.
module pc_next
  import mips_pkg::*;
(
  input  logic [31:0]       i_pcplus4,
  input  logic [JIDX_MSB:0] i_instr,
  input  logic              i_pcsrc,
  input  logic              i_jump,
  output logic [31:0]       o_next_pc
);

  logic [31:0] w_jump_target;
  logic [31:0] w_branch_target;

  assign w_jump_target   = {i_pcplus4[31:28], i_instr[JIDX_MSB:0], 2'b00};
  assign w_branch_target = i_pcplus4 + branch_offset(i_instr[IMM_MSB:0]);

  // Jump is checked first so it wins when both controls are high
  always_comb begin
    o_next_pc = i_pcplus4;
    if (i_jump) begin
      o_next_pc = w_jump_target;
    end else if (i_pcsrc) begin
      o_next_pc = w_branch_target;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Two-state instruction fetch unit: requests the word at pc, holds it for
// the datapath until advance, then loads the next PC and counts retirement.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC                        = RESET_PC_DEFAULT,
  parameter int          BRANCH_JUMP_BOTH_HIGH_JUMP_WINS = 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        advance,
  input  logic        pcsrc,
  input  logic        jump,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic [31:0] retired
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic [31:0]  r_retired;
  logic [31:0]  w_pc_next;
  logic [31:0]  w_instr_next;
  logic [31:0]  w_retired_next;
  logic [31:0]  w_pcplus4;
  logic [31:0]  w_target_pc;

  assign w_pcplus4 = r_pc + 32'd4;

  pc_next u_pc_next (
    .i_pcplus4 (w_pcplus4),
    .i_instr   (r_instr[JIDX_MSB:0]),
    .i_pcsrc   (pcsrc),
    .i_jump    (jump),
    .o_next_pc (w_target_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= FETCH;
      r_pc      <= RESET_PC;
      r_instr   <= '0;
      r_retired <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pc      <= w_pc_next;
      r_instr   <= w_instr_next;
      r_retired <= w_retired_next;
    end
  end

  // Ack is only looked at in FETCH; advance/pcsrc/jump only in EXEC
  always_comb begin
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_instr_next   = r_instr;
    w_retired_next = r_retired;
    imem_req       = 1'b0;
    instr_valid    = 1'b0;
    case (r_state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          w_instr_next = imem_rdata;
          w_state_next = EXEC;
        end
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (advance) begin
          w_pc_next      = w_target_pc;
          w_retired_next = r_retired + 32'd1;
          w_state_next   = FETCH;
        end
      end
      default: w_state_next = FETCH;
    endcase
  end

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign pcplus4   = w_pcplus4;
  assign instr     = r_instr;
  assign retired   = r_retired;

  // With jump priority disabled, a simultaneous branch and jump is illegal
  generate
    if (BRANCH_JUMP_BOTH_HIGH_JUMP_WINS == 0) begin : g_both_illegal
      always_ff @(posedge clk) begin
        if (!reset && r_state == EXEC && advance) begin
          assert (!(pcsrc && jump));
        end
      end
    end
  endgenerate

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC loaded on reset.
REQ-002 The block SHALL have parameter BRANCH_JUMP_BOTH_HIGH_JUMP_WINS, default 1, where 1 gives jump priority and 0 makes the pair illegal (assertion only).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 imem_req  out  1  instruction memory read request.
REQ-006 imem_addr  out  32  byte address of the requested word, equal to pc.
REQ-007 imem_ack  in  1  memory read data valid this cycle.
REQ-008 imem_rdata  in  32  instruction word, sampled when imem_req & imem_ack.
REQ-009 instr  out  32  held instruction; op field instr[31:26] feeds the main decoder.
REQ-010 instr_valid  out  1  instr is valid and awaiting execution.
REQ-011 advance  in  1  datapath completes the held instruction this cycle.
REQ-012 pcsrc  in  1  branch taken (branch & zero), sampled with advance.
REQ-013 jump  in  1  jump control from the decoder, sampled with advance.
REQ-014 pc  out  32  address of the held or requested instruction.
REQ-015 pcplus4  out  32  pc + 4, modulo 2^32.
REQ-016 retired  out  32  count of instructions completed since reset.

Function
REQ-017 The block SHALL implement a two-state FSM, FETCH and EXEC.
REQ-018 In FETCH, imem_req SHALL be 1 and imem_addr SHALL hold pc stable until ack.
REQ-019 In FETCH with imem_ack=1, the block SHALL capture imem_rdata into instr and go to EXEC next cycle.
REQ-020 In FETCH with imem_ack=0, the block SHALL stay in FETCH with no limit on wait cycles.
REQ-021 In EXEC, imem_req SHALL be 0, instr_valid SHALL be 1 and instr SHALL be held constant.
REQ-022 In EXEC with advance=0, the block SHALL hold state, pc and instr.
REQ-023 In EXEC with advance=1, the block SHALL load pc with the next PC, increment retired, and enter FETCH.
REQ-024 When jump=1, next PC SHALL be {pcplus4[31:28], instr[25:0], 2'b00}.
REQ-025 When jump=0 and pcsrc=1, next PC SHALL be pcplus4 + (sign-extended instr[15:0] << 2), truncated to 32 bits.
REQ-026 Otherwise, next PC SHALL be pcplus4.
REQ-027 When jump=1 and pcsrc=1, jump SHALL win.
REQ-028 advance, pcsrc and jump SHALL be ignored in FETCH.
REQ-029 imem_ack SHALL be ignored in EXEC.
REQ-030 All PC arithmetic and retired SHALL wrap modulo 2^32 without flagging.
REQ-031 Minimum instruction period SHALL be 2 cycles: ack at cycle n, then advance at cycle n+1.

Reset
REQ-032 When reset=1 at a clock edge, the block SHALL set state=FETCH, pc=RESET_PC, instr=0, retired=0.
REQ-033 After that reset edge, the outputs SHALL be imem_req=1 and instr_valid=0.
REQ-034 Reset SHALL take precedence over imem_ack and advance in the same cycle.
REQ-035 A request in flight at reset SHALL be abandoned, and its ack SHALL be taken as data for RESET_PC.

Structure
REQ-036 Shared package mips_pkg SHALL hold the FSM state encoding, opcode field positions and the RESET_PC default.
REQ-037 Next-PC selection SHALL be a combinational sub-module pc_next (inputs pcplus4, instr, pcsrc, jump; output 32-bit next PC).
REQ-038 Registers SHALL be state, pc, instr and retired only.
REQ-039 pcplus4, imem_addr, imem_req and instr_valid SHALL be decoded from these registers.

Verification
REQ-040 Reset then ack=1 with rdata=32'h8C08_0004 -> imem_addr=0, instr=32'h8C08_0004, instr_valid=1 one cycle later.
REQ-041 Advance with pcsrc=0, jump=0 from pc=0 -> pc=4, imem_req=1, retired=1.
REQ-042 instr=32'h1000_FFFF with pcsrc=1 at pc=8 -> pc=8 (branch to self), then instr=32'h0810_0000 with jump=1 -> pc=32'h0040_0000.
REQ-043 pcsrc=1 and jump=1 together -> jump target taken; pc=32'hFFFF_FFFC with sequential advance -> pc=0.
REQ-044 imem_ack held 0 for 5 cycles -> imem_req=1 and imem_addr stable throughout; advance pulsed in FETCH -> no effect.
REQ-045 reset asserted in EXEC with advance=1 -> pc=RESET_PC, retired=0, state FETCH.
